// File: rtl/vga_scan_ctrl.sv
// Parametrised VGA scan controller: pixel divider, h/v timing, windowed and
// scaled image ROM addressing, and a two-stage registered pixel pipeline.
module vga_scan_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int SCALE    = 0,
    parameter int X0       = 0,
    parameter int Y0       = 0,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [11:0]       bg,
    input  logic [11:0]       rdata,
    output logic [ADDR_W-1:0] raddr,
    output logic              hs,
    output logic              vs,
    output logic              de,
    output logic [11:0]       prgb,
    output logic              frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(CLK_DIV);
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int WIN_W = IMG_W << SCALE;
    localparam int WIN_H = IMG_H << SCALE;
    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    logic [DW-1:0] r_dcnt;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic          r_act1;
    logic          r_hs1;
    logic          r_vs1;
    logic          r_win1;

    logic w_pe;
    logic w_hEnd;
    logic w_vEnd;
    logic w_act;
    logic w_hsOn;
    logic w_vsOn;
    logic w_win;
    int   w_h;
    int   w_v;

    assign w_pe   = (r_dcnt == DW'(CLK_DIV - 1));
    assign w_hEnd = (r_hcnt == HW'(H_TOT - 1));
    assign w_vEnd = (r_vcnt == VW'(V_TOT - 1));
    assign w_h    = int'(r_hcnt);
    assign w_v    = int'(r_vcnt);
    assign w_act  = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_hsOn = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign w_vsOn = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
    // The window test includes w_act so parts hanging past the active area are never addressed
    assign w_win  = w_act && (w_h >= X0) && (w_h < X0 + WIN_W)
                          && (w_v >= Y0) && (w_v < Y0 + WIN_H);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dcnt      <= '0;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            r_dcnt      <= w_pe ? '0 : r_dcnt + 1'b1;
            if (w_pe) begin
                if (w_hEnd) begin
                    r_hcnt <= '0;
                    if (w_vEnd) begin
                        r_vcnt      <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        r_vcnt <= r_vcnt + 1'b1;
                    end
                end else begin
                    r_hcnt <= r_hcnt + 1'b1;
                end
            end
        end
    end

    // Stage 1 issues the ROM address so rdata is settled by the next pixel edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act1 <= 1'b0;
            r_hs1  <= ~HS_ACT;
            r_vs1  <= ~VS_ACT;
            r_win1 <= 1'b0;
            raddr  <= '0;
        end else if (w_pe) begin
            r_act1 <= w_act;
            r_hs1  <= w_hsOn ? HS_ACT : ~HS_ACT;
            r_vs1  <= w_vsOn ? VS_ACT : ~VS_ACT;
            r_win1 <= w_win;
            if (w_win) begin
                raddr <= ADDR_W'((((w_v - Y0) >> SCALE) * IMG_W) + ((w_h - X0) >> SCALE));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs   <= ~HS_ACT;
            vs   <= ~VS_ACT;
            de   <= 1'b0;
            prgb <= 12'h000;
        end else if (w_pe) begin
            hs <= r_hs1;
            vs <= r_vs1;
            de <= r_act1;
            if (!r_act1 || !en) begin
                prgb <= 12'h000;
            end else if (r_win1) begin
                prgb <= rdata;
            end else begin
                prgb <= bg;
            end
        end
    end

endmodule
